tlk2711_cmd_arb: RTL

- Parametrised N-channel command arbiter in front of the shared tlk2711_dma command port (read or write side; one instance per side).
- Lets multiple tx_cmd/rx_link channels share one DMA engine using round-robin grant.
- Completion (rd_last / wr_finish) is routed back to the owning channel.
- Generalises the single req/ack command path to NUM_CH channels, with per-channel enable, an optional done-wait mode and a grant-ID output.

---
 rtl/tlk2711_cmd_arb_if.sv | 26 ++
 rtl/tlk2711_cmd_arb.sv | 135 +++++++++++++
 2 files changed

// File: rtl/tlk2711_cmd_arb_if.sv
// Command-port bundle between the channel arbiter (master) and the shared
// tlk2711_dma command interface (slave).
interface tlk2711_cmd_arb_if #(
  parameter int DATA_WIDTH = 64
) ();

  logic                  cmd_req;
  logic [DATA_WIDTH-1:0] cmd_data;
  logic                  cmd_ack;
  logic                  dma_done;

  modport master (
    output cmd_req,
    output cmd_data,
    input  cmd_ack,
    input  dma_done
  );

  modport slave (
    input  cmd_req,
    input  cmd_data,
    output cmd_ack,
    output dma_done
  );

endinterface

// File: rtl/tlk2711_cmd_arb.sv
// Round-robin arbiter sharing one tlk2711_dma command port between NUM_CH
// channels; accept and completion pulses are routed back to the granted channel.
module tlk2711_cmd_arb #(
  parameter int    NUM_CH      = 4,
  parameter int    CH_ID_WIDTH = 2,
  parameter int    ADDR_WIDTH  = 48,
  parameter int    DLEN_WIDTH  = 16,
  parameter string WAIT_DONE   = "TRUE"
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        i_soft_rst,
  input  logic [NUM_CH-1:0]                           i_ch_ena,
  input  logic [NUM_CH-1:0]                           i_ch_req,
  input  logic [NUM_CH*(DLEN_WIDTH+ADDR_WIDTH)-1:0]   i_ch_data,
  output logic [NUM_CH-1:0]                           o_ch_ack,
  output logic [NUM_CH-1:0]                           o_ch_done,
  output logic [CH_ID_WIDTH-1:0]                      o_grant_id,
  output logic                                        o_busy,
  tlk2711_cmd_arb_if.master                           dma
);

  localparam int                   DW       = DLEN_WIDTH + ADDR_WIDTH;
  localparam bit                   WAIT_EN  = (WAIT_DONE == "TRUE");
  localparam logic [CH_ID_WIDTH-1:0] PTR_INIT = CH_ID_WIDTH'(NUM_CH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [CH_ID_WIDTH-1:0] ptr;
  logic [CH_ID_WIDTH-1:0] ptr_nxt;
  logic [CH_ID_WIDTH-1:0] grant_nxt;
  logic [DW-1:0]          cmd_data_q;
  logic [DW-1:0]          data_nxt;
  logic [NUM_CH-1:0]      ack_nxt;
  logic [NUM_CH-1:0]      done_nxt;
  logic [NUM_CH-1:0]      elig;
  logic                   found;
  logic [CH_ID_WIDTH-1:0] winner;
  logic [CH_ID_WIDTH-1:0] idx;
  logic [DW-1:0]          ch_cmd [NUM_CH];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
    assign ch_cmd[g] = i_ch_data[g*DW +: DW];
  end

  assign elig         = i_ch_req & i_ch_ena;
  assign o_busy       = (state != S_IDLE);
  assign dma.cmd_req  = (state == S_REQ);
  assign dma.cmd_data = cmd_data_q;

  // Scan from the farthest offset down so the last hit is the one nearest ptr+1.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int i = NUM_CH; i >= 1; i--) begin
      idx = CH_ID_WIDTH'((int'(ptr) + i) % NUM_CH);
      if (elig[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    grant_nxt = o_grant_id;
    data_nxt  = cmd_data_q;
    ack_nxt   = '0;
    done_nxt  = '0;
    case (state)
      S_IDLE: begin
        if (found) begin
          state_nxt = S_REQ;
          grant_nxt = winner;
          data_nxt  = ch_cmd[winner];
        end
      end
      S_REQ: begin
        if (dma.cmd_ack) begin
          ack_nxt[o_grant_id] = 1'b1;
          if (WAIT_EN) begin
            state_nxt = S_WAIT;
          end else begin
            state_nxt = S_IDLE;
            ptr_nxt   = o_grant_id;
          end
        end
      end
      S_WAIT: begin
        if (dma.dma_done) begin
          done_nxt[o_grant_id] = 1'b1;
          ptr_nxt              = o_grant_id;
          state_nxt            = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    // Soft reset overrides everything, including an ack arriving the same cycle.
    if (i_soft_rst) begin
      state_nxt = S_IDLE;
      ptr_nxt   = PTR_INIT;
      grant_nxt = '0;
      data_nxt  = '0;
      ack_nxt   = '0;
      done_nxt  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      ptr        <= PTR_INIT;
      o_grant_id <= '0;
      cmd_data_q <= '0;
      o_ch_ack   <= '0;
      o_ch_done  <= '0;
    end else begin
      state      <= state_nxt;
      ptr        <= ptr_nxt;
      o_grant_id <= grant_nxt;
      cmd_data_q <= data_nxt;
      o_ch_ack   <= ack_nxt;
      o_ch_done  <= done_nxt;
    end
  end

endmodule
